// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared widths and types for the two-master peripheral bus
// arbiter. Imported by the interface, the winner-select sub-module and the top.
package periph_bus_pkg;
  localparam int AW = 16;  // byte address width
  localparam int DW = 16;  // data width
  localparam int BW = 2;   // byte write enable width
  localparam int NM = 2;   // number of masters

  typedef logic [0:0] mid_t;  // master id

  localparam logic [BW-1:0] BWE_READ = 2'b00;

  // One master command as presented on the request side
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] bwe;
    logic [DW-1:0] din;
  } cmd_t;
endpackage

// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: bundles both master request/response channels and the
// slave command/read-data channel.
//   modport slave  : the arbiter view (takes master requests, drives s_*)
//   modport master : the requester/slave-model view (testbench, CPU, monitor)
interface periph_bus_arbiter_if;
  import periph_bus_pkg::*;

  logic          m0_req,    m1_req;
  logic          m0_lock,   m1_lock;
  logic [AW-1:0] m0_addr,   m1_addr;
  logic [BW-1:0] m0_bwe,    m1_bwe;
  logic [DW-1:0] m0_din,    m1_din;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata,  m1_rdata;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_bwe;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;

  modport slave (
    input  m0_req, m1_req, m0_lock, m1_lock, m0_addr, m1_addr,
           m0_bwe, m1_bwe, m0_din, m1_din, s_dout,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           s_addr, s_bwe, s_din
  );

  modport master (
    output m0_req, m1_req, m0_lock, m1_lock, m0_addr, m1_addr,
           m0_bwe, m1_bwe, m0_din, m1_din, s_dout,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           s_addr, s_bwe, s_din
  );
endinterface

// File: rtl/periph_arb_pick.sv
// periph_arb_pick: combinational winner select for the two-master arbiter.
// Ports:
//   req_i   : per-master request
//   lock_i  : owner holds the lock from its last grant
//   owner_i : master granted most recently (lock holder)
//   last_i  : round-robin pointer (only with PERIPH_ARB_RR_EN)
//   vld_o   : a master wins this edge
//   id_o    : winning master
// Build option PERIPH_ARB_RR_EN: round-robin tie-break; otherwise master 0
// always wins ties. Lock takes precedence in both builds.
module periph_arb_pick
  import periph_bus_pkg::*;
(
  input  logic [NM-1:0] req_i,
  input  logic          lock_i,
  input  mid_t          owner_i,
`ifdef PERIPH_ARB_RR_EN
  input  mid_t          last_i,
`endif
  output logic          vld_o,
  output mid_t          id_o
);

  mid_t tie_id;

`ifdef PERIPH_ARB_RR_EN
  assign tie_id = ~last_i;
`else
  assign tie_id = '0;
`endif

  always_comb begin
    vld_o = |req_i;
    id_o  = '0;
    if (lock_i && req_i[owner_i]) id_o = owner_i;
    else if (&req_i)              id_o = tie_id;
    else                          id_o = mid_t'(req_i[1]);  // lone requester
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: shares one 16-bit peripheral slave (registered read,
// one-cycle latency) between master 0 (CPU) and master 1 (UART monitor).
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : periph_bus_arbiter_if.slave -- m*_req/lock/addr/bwe/din in,
//                m*_gnt/rvalid/rdata out, s_addr/s_bwe/s_din out, s_dout in
// Build option PERIPH_ARB_RR_EN: round-robin tie-break (else fixed priority m0).
// Timing: req sampled at E0 -> gnt + s_* in cycle 1 -> slave latches dout at
// E1 -> rvalid/rdata to the owning master in cycle 2.
module periph_bus_arbiter
  import periph_bus_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  periph_bus_arbiter_if.slave bus
);

  logic [NM-1:0]         req, lock;
  cmd_t [NM-1:0]         cmd;
  logic                  win_vld;
  mid_t                  win_id;
  logic                  lock_q, lock_d;
  mid_t                  owner_q, owner_d;
  logic [AW-1:0]         s_addr_q;
  logic [BW-1:0]         s_bwe_q;
  logic [DW-1:0]         s_din_q;
  // Owner pipeline: stage 1 = grant cycle, stage 2 = completion cycle
  logic [2:1]            vld_pipe;
  logic [2:1]            id_pipe;
  logic [NM-1:0]         gnt, rvalid;
  logic [NM-1:0][DW-1:0] rdata, rdata_q;

  assign req    = {bus.m1_req,  bus.m0_req};
  assign lock   = {bus.m1_lock, bus.m0_lock};
  assign cmd[0] = '{addr: bus.m0_addr, bwe: bus.m0_bwe, din: bus.m0_din};
  assign cmd[1] = '{addr: bus.m1_addr, bwe: bus.m1_bwe, din: bus.m1_din};

`ifdef PERIPH_ARB_RR_EN
  mid_t last_q;

  // Resets to 1 so master 0 takes the first tie
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       last_q <= mid_t'(1'b1);
    else if (win_vld) last_q <= win_id;
`endif

  periph_arb_pick u_pick (
    .req_i   (req),
    .lock_i  (lock_q),
    .owner_i (owner_q),
`ifdef PERIPH_ARB_RR_EN
    .last_i  (last_q),
`endif
    .vld_o   (win_vld),
    .id_o    (win_id)
  );

  // Lock follows the winner's lock bit; an edge with no winner drops it
  always_comb begin
    lock_d  = 1'b0;
    owner_d = owner_q;
    if (win_vld) begin
      lock_d  = lock[win_id];
      owner_d = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end

  // Idle edges issue a harmless read at the held address
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_addr_q <= '0;
      s_bwe_q  <= BWE_READ;
      s_din_q  <= '0;
    end else if (win_vld) begin
      s_addr_q <= cmd[win_id].addr;
      s_bwe_q  <= cmd[win_id].bwe;
      s_din_q  <= cmd[win_id].din;
    end else begin
      s_bwe_q  <= BWE_READ;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], win_vld};
      id_pipe  <= {id_pipe[1],  win_id};
    end

  // Owner sees live slave data in its rvalid cycle, then keeps it
  for (genvar m = 0; m < NM; m++) begin : g_mst
    assign gnt[m]    = vld_pipe[1] && (id_pipe[1] == mid_t'(m));
    assign rvalid[m] = vld_pipe[2] && (id_pipe[2] == mid_t'(m));
    assign rdata[m]  = rvalid[m] ? bus.s_dout : rdata_q[m];

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)         rdata_q[m] <= '0;
      else if (rvalid[m]) rdata_q[m] <= bus.s_dout;
  end

  assign bus.m0_gnt    = gnt[0];
  assign bus.m1_gnt    = gnt[1];
  assign bus.m0_rvalid = rvalid[0];
  assign bus.m1_rvalid = rvalid[1];
  assign bus.m0_rdata  = rdata[0];
  assign bus.m1_rdata  = rdata[1];
  assign bus.s_addr    = s_addr_q;
  assign bus.s_bwe     = s_bwe_q;
  assign bus.s_din     = s_din_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Testbench for periph_bus_arbiter: per-master command drivers, a small
// LED/SSD/switch/button slave model, and a scoreboard of expected grants and
// completions checked by a negedge monitor.
module tb_periph_bus_arbiter;
  import periph_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  periph_bus_arbiter_if bus();

  periph_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {logic [15:0] addr; logic [1:0] bwe; logic [15:0] din; logic lock;} mcmd_t;
  typedef struct {int m; logic [15:0] addr; logic [1:0] bwe; logic [15:0] din;} gexp_t;
  typedef struct {int m; logic [15:0] data; bit chk_data; bit b2b;} rexp_t;

  mcmd_t q0[$], q1[$];
  gexp_t gq[$];
  rexp_t rq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_rv_cyc = -100;

  localparam logic [15:0] SW  = 16'h00A5;
  localparam logic [15:0] BTN = 16'h0009;
  logic [15:0] led_r = '0, ssd_r = '0;

  // Slave: 0x0 LED, 0x2 SSD, 0x4 switches, 0x6 buttons; registered read
  always @(posedge clk) begin
    case (bus.s_addr[2:1])
      2'd0:    bus.s_dout <= led_r;
      2'd1:    bus.s_dout <= ssd_r;
      2'd2:    bus.s_dout <= SW;
      default: bus.s_dout <= BTN;
    endcase
    if (bus.s_addr[2:1] == 2'd0) begin
      if (bus.s_bwe[0]) led_r[7:0]  <= bus.s_din[7:0];
      if (bus.s_bwe[1]) led_r[15:8] <= bus.s_din[15:8];
    end
    if (bus.s_addr[2:1] == 2'd1) begin
      if (bus.s_bwe[0]) ssd_r[7:0]  <= bus.s_din[7:0];
      if (bus.s_bwe[1]) ssd_r[15:8] <= bus.s_din[15:8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_addr"},    32'(bus.s_addr),    0);
    chk({tag, "_s_bwe"},     32'(bus.s_bwe),     0);
    chk({tag, "_s_din"},     32'(bus.s_din),     0);
    chk({tag, "_m0_gnt"},    32'(bus.m0_gnt),    0);
    chk({tag, "_m1_gnt"},    32'(bus.m1_gnt),    0);
    chk({tag, "_m0_rvalid"}, 32'(bus.m0_rvalid), 0);
    chk({tag, "_m1_rvalid"}, 32'(bus.m1_rvalid), 0);
    chk({tag, "_m0_rdata"},  32'(bus.m0_rdata),  0);
    chk({tag, "_m1_rdata"},  32'(bus.m1_rdata),  0);
  endtask

  task automatic issue(input int m, input logic [15:0] a, input logic [1:0] be,
                       input logic [15:0] d, input logic lk);
    mcmd_t c;
    c = '{addr: a, bwe: be, din: d, lock: lk};
    if (m == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  task automatic exp_g(input int m, input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
    gq.push_back('{m: m, addr: a, bwe: be, din: d});
  endtask

  task automatic exp_r(input int m, input logic [15:0] d, input bit cd, input bit b2b);
    rq.push_back('{m: m, data: d, chk_data: cd, b2b: b2b});
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((q0.size() + q1.size() + gq.size() + rq.size()) != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({"drain_", nm}, 32'(t < 60), 1);
    repeat (2) @(negedge clk);
  endtask

  // Drivers: a command accepted at an edge is replaced (or req dropped) in its gnt cycle
  initial begin : drv0
    bus.m0_req = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_bwe = '0; bus.m0_din = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m0_gnt && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        bus.m0_req = 1; bus.m0_lock = q0[0].lock; bus.m0_addr = q0[0].addr;
        bus.m0_bwe = q0[0].bwe; bus.m0_din = q0[0].din;
      end else begin
        bus.m0_req = 0; bus.m0_lock = 0;
      end
    end
  end

  initial begin : drv1
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_bwe = '0; bus.m1_din = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.m1_gnt && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        bus.m1_req = 1; bus.m1_lock = q1[0].lock; bus.m1_addr = q1[0].addr;
        bus.m1_bwe = q1[0].bwe; bus.m1_din = q1[0].din;
      end else begin
        bus.m1_req = 0; bus.m1_lock = 0;
      end
    end
  end

  // Monitor: every grant and every completion must match the scoreboard head
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    int m;
    cyc++;
    if (bus.m0_gnt || bus.m1_gnt) begin
      m = bus.m1_gnt ? 1 : 0;
      chk("gnt_onehot", 32'(bus.m0_gnt & bus.m1_gnt), 0);
      if (gq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_gnt: got m%0d expected none", m);
      end else begin
        g = gq.pop_front();
        chk("gnt_master", 32'(m), 32'(g.m));
        chk("s_addr", 32'(bus.s_addr), 32'(g.addr));
        chk("s_bwe", 32'(bus.s_bwe), 32'(g.bwe));
        if (g.bwe != 2'b00) chk("s_din", 32'(bus.s_din), 32'(g.din));
      end
    end
    if (bus.m0_rvalid || bus.m1_rvalid) begin
      m = bus.m1_rvalid ? 1 : 0;
      chk("rvalid_onehot", 32'(bus.m0_rvalid & bus.m1_rvalid), 0);
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rvalid: got m%0d expected none", m);
      end else begin
        r = rq.pop_front();
        chk("rvalid_master", 32'(m), 32'(r.m));
        if (r.chk_data) chk("rdata", 32'(m ? bus.m1_rdata : bus.m0_rdata), 32'(r.data));
        if (r.b2b) chk("rvalid_b2b_gap", 32'(cyc - last_rv_cyc), 1);
      end
      last_rv_cyc = cyc;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // m0 single read of the switches
    issue(0, 16'h0004, 2'b00, 16'h0, 1'b0);
    exp_g(0, 16'h0004, 2'b00, 16'h0);
    exp_r(0, 16'h00A5, 1'b1, 1'b0);
    drain("m0_read");

    // m1 full-word write to the seven-segment register
    issue(1, 16'h0002, 2'b11, 16'h1234, 1'b0);
    exp_g(1, 16'h0002, 2'b11, 16'h1234);
    exp_r(1, 16'h0, 1'b0, 1'b0);
    drain("m1_write");
    chk("ssd_after_write", 32'(ssd_r), 32'h1234);

    // Both masters request continuously
    for (int i = 0; i < 3; i++) begin
      issue(0, 16'h0004, 2'b00, 16'h0, 1'b0);
      issue(1, 16'h0006, 2'b00, 16'h0, 1'b0);
    end
`ifdef PERIPH_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      exp_g(0, 16'h0004, 2'b00, 16'h0); exp_r(0, 16'h00A5, 1'b1, 1'b0);
      exp_g(1, 16'h0006, 2'b00, 16'h0); exp_r(1, 16'h0009, 1'b1, 1'b0);
    end
`else
    for (int i = 0; i < 3; i++) begin
      exp_g(0, 16'h0004, 2'b00, 16'h0); exp_r(0, 16'h00A5, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      exp_g(1, 16'h0006, 2'b00, 16'h0); exp_r(1, 16'h0009, 1'b1, 1'b0);
    end
`endif
    drain("contend");

    // m1 locked across 3 requests while m0 waits
    issue(1, 16'h0006, 2'b00, 16'h0, 1'b1);
    issue(1, 16'h0006, 2'b00, 16'h0, 1'b1);
    issue(1, 16'h0006, 2'b00, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_g(1, 16'h0006, 2'b00, 16'h0); exp_r(1, 16'h0009, 1'b1, 1'b0);
    end
    exp_g(0, 16'h0004, 2'b00, 16'h0); exp_r(0, 16'h00A5, 1'b1, 1'b0);
    @(negedge clk);
    issue(0, 16'h0004, 2'b00, 16'h0, 1'b0);
    drain("lock");

    // Back-to-back m0 reads: completions in consecutive cycles
    issue(0, 16'h0004, 2'b00, 16'h0, 1'b0);
    issue(0, 16'h0006, 2'b00, 16'h0, 1'b0);
    exp_g(0, 16'h0004, 2'b00, 16'h0); exp_r(0, 16'h00A5, 1'b1, 1'b0);
    exp_g(0, 16'h0006, 2'b00, 16'h0); exp_r(0, 16'h0009, 1'b1, 1'b1);
    drain("b2b");

    // Reset asserted during the grant cycle of a read
    issue(0, 16'h0004, 2'b00, 16'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("gnt_before_rst", 32'(bus.m0_gnt), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First tie after reset goes to m0
    issue(0, 16'h0004, 2'b00, 16'h0, 1'b0);
    issue(1, 16'h0006, 2'b00, 16'h0, 1'b0);
    exp_g(0, 16'h0004, 2'b00, 16'h0); exp_r(0, 16'h00A5, 1'b1, 1'b0);
    exp_g(1, 16'h0006, 2'b00, 16'h0); exp_r(1, 16'h0009, 1'b1, 1'b0);
    drain("tie_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
